matrix_multiplier_2x2: RTL and testbench

Sequential signed fixed-point 2x2 matrix multiplier, Res = A·B, for the Kalman filter datapath. It sits directly downstream of the 2x2 inverter and forms the Kalman gain K = P·S⁻¹ from the predicted covariance and the inverted innovation covariance. Its start/end handshake matches the inverter so the two chain without glue. It uses one time-multiplexed multiplier and one accumulator.

---
 rtl/matrix_multiplier_2x2_if.sv | 19 +
 rtl/matrix_multiplier_2x2.sv | 105 ++++++++++
 tb/tb_matrix_multiplier_2x2.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/matrix_multiplier_2x2_if.sv
// Handshake and operand/result bundle for the 2x2 matrix multiplier.
//   startMul : request to start a multiply (master -> slave)
//   A, B     : signed 2x2 operand matrices (master -> slave)
//   Res      : signed 2x2 product matrix (slave -> master)
//   busy     : multiply in progress (slave -> master)
//   endMul   : one-cycle completion pulse, Res valid (slave -> master)
interface matrix_multiplier_2x2_if #(
  parameter int WIDTH = 16
);
  logic                    startMul;
  logic signed [WIDTH-1:0] A   [0:1][0:1];
  logic signed [WIDTH-1:0] B   [0:1][0:1];
  logic signed [WIDTH-1:0] Res [0:1][0:1];
  logic                    busy;
  logic                    endMul;

  modport master (output startMul, A, B, input Res, busy, endMul);
  modport slave  (input startMul, A, B, output Res, busy, endMul);
endinterface

// File: rtl/matrix_multiplier_2x2.sv
// Sequential signed fixed-point 2x2 matrix multiplier, Res = A*B, using one
// time-multiplexed multiplier and one accumulator (8 MAC cycles per multiply).
// Ports:
//   clk : clock, all logic on posedge
//   rst : synchronous active-high reset
//   mm  : slave side of matrix_multiplier_2x2_if (startMul, A, B in;
//         Res, busy, endMul out, all outputs registered)
module matrix_multiplier_2x2 #(
  parameter int WIDTH    = 16,
  parameter int fracBits = 8
) (
  input logic                   clk,
  input logic                   rst,
  matrix_multiplier_2x2_if.slave mm
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                    state_q;
  logic [2:0]                cnt_q;
  logic signed [2*WIDTH:0]   acc_q;
  logic signed [WIDTH-1:0]   Ar_q  [0:1][0:1];
  logic signed [WIDTH-1:0]   Br_q  [0:1][0:1];
  logic signed [WIDTH-1:0]   res_q [0:1][0:1];
  logic                      busy_q;
  logic                      end_q;

  logic                      idx_i, idx_j, idx_k;
  logic signed [WIDTH-1:0]   op_a, op_b;
  logic signed [2*WIDTH-1:0] op_a_ext, op_b_ext, prod;
  logic signed [2*WIDTH:0]   sum_d, shifted, sat_hi, sat_lo;
  logic signed [WIDTH-1:0]   sat_d;

  // Datapath: one product per cycle, indices decoded from cnt.
  always_comb begin
    idx_i    = cnt_q[2];
    idx_j    = cnt_q[1];
    idx_k    = cnt_q[0];
    op_a     = Ar_q[idx_i][idx_k];
    op_b     = Br_q[idx_k][idx_j];
    // Operands widened so the 2*WIDTH-bit product is exact.
    op_a_ext = {{WIDTH{op_a[WIDTH-1]}}, op_a};
    op_b_ext = {{WIDTH{op_b[WIDTH-1]}}, op_b};
    prod     = op_a_ext * op_b_ext;
    sum_d    = acc_q + {prod[2*WIDTH-1], prod};
    shifted  = sum_d >>> fracBits;
    sat_hi   = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    sat_lo   = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
    if (shifted > sat_hi)
      sat_d = {1'b0, {(WIDTH-1){1'b1}}};
    else if (shifted < sat_lo)
      sat_d = {1'b1, {(WIDTH-1){1'b0}}};
    else
      sat_d = shifted[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
      for (int unsigned r = 0; r < 2; r++)
        for (int unsigned c = 0; c < 2; c++)
          res_q[r][c] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          end_q <= 1'b0;
          if (mm.startMul) begin
            Ar_q    <= mm.A;
            Br_q    <= mm.B;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MAC;
          end
        end
        MAC: begin
          if (!idx_k)
            acc_q <= {prod[2*WIDTH-1], prod};
          else
            res_q[idx_i][idx_j] <= sat_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            end_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          end_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mm.Res    = res_q;
  assign mm.busy   = busy_q;
  assign mm.endMul = end_q;

endmodule

// File: tb/tb_matrix_multiplier_2x2.sv
module tb_matrix_multiplier_2x2;

  typedef logic signed [15:0] mat_t [0:1][0:1];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  matrix_multiplier_2x2_if #(.WIDTH(16)) bus ();

  matrix_multiplier_2x2 #(.WIDTH(16), .fracBits(8)) dut (
    .clk (clk),
    .rst (rst),
    .mm  (bus)
  );

  // Advance one edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input mat_t exp);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        chk($sformatf("%s_res%0d%0d", tag, r, c), {16'h0, bus.Res[r][c]}, {16'h0, exp[r][c]});
  endtask

  // Runs one complete multiply from IDLE; checks latency, pulse width, busy and Res.
  task automatic run_op(input string tag, input mat_t a, input mat_t b, input mat_t exp);
    int end_at, end_cnt, busy_cnt;
    mat_t junk;
    junk = '{'{16'sh1234, 16'sh5678}, '{16'sh7ABC, 16'sh4DEF}};
    bus.A = a;
    bus.B = b;
    bus.startMul = 1'b1;
    step();                       // edge 0
    bus.startMul = 1'b0;
    bus.A = junk;                 // operands must already be latched
    bus.B = junk;
    end_at = -1; end_cnt = 0; busy_cnt = 0;
    if (bus.busy === 1'b1) busy_cnt++;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.endMul === 1'b1) begin
        end_cnt++;
        if (end_at < 0) end_at = e;
      end
    end
    chk({tag, "_latency"}, end_at, 8);
    chk({tag, "_endcnt"}, end_cnt, 1);
    chk({tag, "_busycnt"}, busy_cnt, 9);
    chk_res(tag, exp);
  endtask

  initial begin
    mat_t a, b, e, a2, z;
    int cnt, first, second;
    z = '{'{16'sh0000, 16'sh0000}, '{16'sh0000, 16'sh0000}};
    bus.startMul = 1'b0;
    bus.A = z;
    bus.B = z;

    // Reset state
    step(); step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_end", bus.endMul, 0);
    chk_res("rst", z);
    rst = 1'b0;
    step();

    // Identity
    a = '{'{16'sh0100, 16'sh0000}, '{16'sh0000, 16'sh0100}};
    b = '{'{16'sh0200, 16'sh0080}, '{16'shFF00, 16'sh0300}};
    run_op("ident", a, b, b);

    // General signed
    a = '{'{16'sh0100, 16'sh0200}, '{16'shFF00, 16'sh0080}};
    b = '{'{16'sh0180, 16'sh0000}, '{16'sh0100, 16'shFF00}};
    e = '{'{16'sh0380, 16'shFE00}, '{16'shFF00, 16'shFF80}};
    run_op("gen", a, b, e);

    // Saturation both directions
    a = '{'{16'sh7FFF, 16'sh7FFF}, '{16'sh8000, 16'sh8000}};
    b = '{'{16'sh7FFF, 16'sh0000}, '{16'sh7FFF, 16'sh0000}};
    e = '{'{16'sh7FFF, 16'sh0000}, '{16'sh8000, 16'sh0000}};
    run_op("sat", a, b, e);

    // Truncation toward -inf
    a = '{'{16'sh0001, 16'sh0000}, '{16'sh0000, 16'sh0000}};
    b = '{'{16'sh0080, 16'sh0000}, '{16'sh0000, 16'sh0000}};
    run_op("trunc_pos", a, b, z);
    a[0][0] = 16'shFFFF;
    e = '{'{16'shFFFF, 16'sh0000}, '{16'sh0000, 16'sh0000}};
    run_op("trunc_neg", a, b, e);

    // Reset at edge 5 of an active multiply
    a = '{'{16'sh0100, 16'sh0200}, '{16'shFF00, 16'sh0080}};
    b = '{'{16'sh0180, 16'sh0000}, '{16'sh0100, 16'shFF00}};
    bus.A = a; bus.B = b; bus.startMul = 1'b1;
    step();                       // edge 0
    bus.startMul = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    rst = 1'b1;
    step();                       // edge 5
    rst = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_end", bus.endMul, 0);
    chk_res("abort", z);
    e = '{'{16'sh0380, 16'shFE00}, '{16'shFF00, 16'shFF80}};
    run_op("after_abort", a, b, e);

    // Start pulses at edges 3 and 9 are ignored
    a  = '{'{16'sh0100, 16'sh0000}, '{16'sh0000, 16'sh0100}};
    a2 = '{'{16'sh0200, 16'sh0000}, '{16'sh0000, 16'sh0200}};
    b  = '{'{16'sh0200, 16'sh0080}, '{16'shFF00, 16'sh0300}};
    bus.A = a; bus.B = b; bus.startMul = 1'b1;
    step();                       // edge 0
    bus.A = a2;
    cnt = 0;
    for (int n = 1; n <= 14; n++) begin
      bus.startMul = (n == 3 || n == 9);
      step();                     // edge n
      if (bus.endMul === 1'b1) cnt++;
    end
    bus.startMul = 1'b0;
    chk("ignore_endcnt", cnt, 1);
    chk("ignore_busy", bus.busy, 0);
    chk_res("ignore", b);

    // startMul held high: endMul every 10 cycles
    bus.A = a; bus.B = b; bus.startMul = 1'b1;
    cnt = 0; first = -1; second = -1;
    for (int n = 0; n <= 21; n++) begin
      step();                     // edge n
      if (bus.endMul === 1'b1) begin
        cnt++;
        if (first < 0) first = n;
        else if (second < 0) second = n;
      end
    end
    bus.startMul = 1'b0;
    chk("held_endcnt", cnt, 2);
    chk("held_first", first, 8);
    chk("held_period", second - first, 10);
    chk_res("held", b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
